// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to instruction
// memory and buffers returned words with their PCs in an in-order prefetch queue.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW:0]   CREDIT  = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   tag_pc  [DEPTH];
    logic [AW-1:0] q_rd, q_wr, tag_rd, tag_wr;
    logic [CW-1:0] count_q, outst_q, drop_q, outst_nxt;
    logic [CW:0]   credit_used;
    logic          req_fire, rsp_keep, pop;

    // Redirect targets are forced to word alignment, so the byte offset is ignored.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req_valid = reset && (credit_used < CREDIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pop            = out_valid && out_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? q_instr[q_rd] : '0;
    assign out_pc    = out_valid ? q_pc[q_rd]    : '0;

    always_comb begin
        outst_nxt = outst_q;
        if (req_fire)
            outst_nxt = outst_nxt + CNT_ONE;
        if (imem_rsp_valid)
            outst_nxt = outst_nxt - CNT_ONE;
    end

    // Control state: PC, pointers and occupancy counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else begin
            outst_q <= outst_nxt;
            if (req_fire)
                tag_wr <= tag_wr + PTR_ONE;
            if (imem_rsp_valid)
                tag_rd <= tag_rd + PTR_ONE;

            if (redirect_valid) begin
                // Everything still in flight, including this cycle's request, is stale.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                count_q  <= '0;
                q_rd     <= '0;
                q_wr     <= '0;
                drop_q   <= outst_nxt;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp_keep)
                    q_wr <= q_wr + PTR_ONE;
                if (pop)
                    q_rd <= q_rd + PTR_ONE;
                case ({rsp_keep, pop})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
                if (imem_rsp_valid && (drop_q != '0))
                    drop_q <= drop_q - CNT_ONE;
            end
        end
    end

    // Data storage: PC tags of in-flight requests and the prefetch queue payload.
    always_ff @(posedge clk) begin
        if (req_fire)
            tag_pc[tag_wr] <= fetch_pc;
        if (rsp_keep) begin
            q_pc[q_wr]    <= tag_pc[tag_rd];
            q_instr[q_wr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-level reference model, in-order memory model
// with configurable latency, and directed scenarios with literal expectations.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk, reset;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid, out_valid, out_ready;
    logic [31:0] redirect_pc, out_instr, out_pc;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_ready(out_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct packed { logic [31:0] pc; logic stale; } fly_t;
    typedef struct packed { logic [31:0] addr; int due; } mreq_t;

    ent_t        dq[$];
    fly_t        fly[$];
    mreq_t       mq[$];
    fly_t        f;
    logic [31:0] m_pc;
    logic        exp_rv, acc;
    int          cyc, mem_lat, total, bad;
    bit          check_en;
    logic [31:0] popped_pc[$], popped_in[$], req_log[$];
    int          pop_cyc[$];
    int          first_req, first_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decode queue and in-flight list with stale marks.
    initial begin
        m_pc = RESET_PC;
        cyc  = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                dq.delete();
                fly.delete();
                mq.delete();
                m_pc = RESET_PC;
            end else begin
                acc = (dq.size() + fly.size() < DEPTH) && imem_req_ready;
                if (out_ready && dq.size() > 0)
                    void'(dq.pop_front());
                if (imem_rsp_valid && fly.size() > 0) begin
                    f = fly.pop_front();
                    if (!f.stale && !redirect_valid)
                        dq.push_back('{pc: f.pc, instr: imem_rsp_data});
                end
                if (acc) begin
                    fly.push_back('{pc: m_pc, stale: 1'b0});
                    mq.push_back('{addr: m_pc, due: cyc + mem_lat - 1});
                end
                if (redirect_valid) begin
                    dq.delete();
                    foreach (fly[i]) fly[i].stale = 1'b1;
                    m_pc = {redirect_pc[31:2], 2'b00};
                end else if (acc) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Instruction memory: in-order responses, fixed latency, data = addr ^ A5A5_0000.
    initial begin
        imem_rsp_valid = 0;
        imem_rsp_data  = 0;
        forever begin
            @(posedge clk);
            #2;
            imem_rsp_valid = 0;
            imem_rsp_data  = 0;
            if (!reset) begin
                mq.delete();
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = mq[0].addr ^ 32'hA5A5_0000;
                void'(mq.pop_front());
            end
        end
    end

    // Per-cycle compare against the model, plus handshake logs for directed checks.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                if (!reset) begin
                    chk("rst_req_valid", imem_req_valid, 0);
                    chk("rst_req_addr", imem_req_addr, RESET_PC);
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_out_instr", out_instr, 0);
                    chk("rst_out_pc", out_pc, 0);
                end else begin
                    exp_rv = (dq.size() + fly.size() < DEPTH);
                    chk("req_valid", imem_req_valid, exp_rv);
                    chk("req_addr", imem_req_addr, m_pc);
                    chk("out_valid", out_valid, dq.size() > 0);
                    if (dq.size() > 0) begin
                        chk("out_pc", out_pc, dq[0].pc);
                        chk("out_instr", out_instr, dq[0].instr);
                    end
                    if (out_valid && out_ready) begin
                        popped_pc.push_back(out_pc);
                        popped_in.push_back(out_instr);
                        pop_cyc.push_back(cyc);
                    end
                    if (imem_req_valid && imem_req_ready)
                        req_log.push_back(imem_req_addr);
                    if (out_valid && first_out < 0)
                        first_out = cyc;
                    if (imem_req_valid && first_req < 0)
                        first_req = cyc;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        popped_pc.delete();
        popped_in.delete();
        pop_cyc.delete();
        req_log.delete();
        first_req = -1;
        first_out = -1;
    endtask

    task automatic do_reset(input int lat);
        reset          = 0;
        check_en       = 1;
        redirect_valid = 0;
        out_ready      = 0;
        imem_req_ready = 0;
        mem_lat        = lat;
        tick();
        tick();
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_req_valid", imem_req_valid, 0);
        tick();
        reset = 1;
        clear_logs();
    endtask

    initial begin
        reset = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        imem_req_ready = 0; mem_lat = 1; total = 0; bad = 0; check_en = 0;
        first_req = -1; first_out = -1;
        #2;

        // Streaming with single-cycle memory.
        do_reset(1);
        imem_req_ready = 1; out_ready = 1;
        repeat (10) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t1_pc", popped_pc[i], 32'(4 * i));
            chk("t1_instr", popped_in[i], 32'hA5A5_0000 ^ 32'(4 * i));
        end
        chk("t1_first_latency", 32'(first_out - first_req), 2);
        chk("t1_throughput", 32'(pop_cyc[4] - pop_cyc[0]), 4);

        // Decode stalled: credit limits requests to DEPTH.
        do_reset(1);
        imem_req_ready = 1; out_ready = 0;
        repeat (8) tick();
        chk("t2_nreq", req_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t2_req", req_log[i], 32'(4 * i));
        @(negedge clk);
        chk("t2_full_stall", imem_req_valid, 0);
        tick();
        out_ready = 1;
        tick();
        out_ready = 0;
        tick();
        tick();
        chk("t2_npop", popped_pc.size(), 1);
        chk("t2_pop_pc", popped_pc[0], 32'h0);
        chk("t2_nreq2", req_log.size(), 5);
        chk("t2_next_req", req_log[4], 32'h10);

        // Redirect with two slow responses in flight.
        do_reset(3);
        imem_req_ready = 1; out_ready = 1;
        tick();
        tick();
        imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 0; imem_req_ready = 1;
        clear_logs();
        repeat (15) tick();
        chk("t3_first_pc", popped_pc[0], 32'h20);
        chk("t3_first_instr", popped_in[0], 32'hA5A5_0020);
        chk("t3_second_pc", popped_pc[1], 32'h24);
        foreach (popped_pc[i])
            chk("t3_no_stale", popped_pc[i] >= 32'h20, 1);

        // Misaligned redirect target.
        do_reset(1);
        imem_req_ready = 1; out_ready = 1;
        repeat (4) tick();
        redirect_valid = 1; redirect_pc = 32'h23;
        tick();
        redirect_valid = 0;
        clear_logs();
        @(negedge clk);
        chk("t4_addr", imem_req_addr, 32'h20);
        chk("t4_out_empty", out_valid, 0);
        repeat (6) tick();
        chk("t4_pc0", popped_pc[0], 32'h20);
        chk("t4_pc1", popped_pc[1], 32'h24);
        chk("t4_instr1", popped_in[1], 32'hA5A5_0024);

        // Memory not ready: address holds.
        do_reset(1);
        imem_req_ready = 1; out_ready = 1;
        tick();
        tick();
        imem_req_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_hold_valid", imem_req_valid, 1);
            chk("t5_hold_addr", imem_req_addr, 32'h8);
            tick();
        end
        imem_req_ready = 1;
        tick();
        tick();
        chk("t5_nreq", req_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t5_req", req_log[i], 32'(4 * i));

        // Reset mid-stream with three queued entries.
        do_reset(1);
        imem_req_ready = 1; out_ready = 0;
        repeat (3) tick();
        imem_req_ready = 0;
        tick();
        @(negedge clk);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_model_count", dq.size(), 3);
        tick();
        reset = 0;
        #1;
        chk("t6_out_valid_now", out_valid, 0);
        chk("t6_req_valid_now", imem_req_valid, 0);
        tick();
        tick();
        reset = 1;
        clear_logs();
        imem_req_ready = 1; out_ready = 1;
        repeat (6) tick();
        chk("t6_restart_req", req_log[0], RESET_PC);
        chk("t6_restart_pc0", popped_pc[0], 32'h0);
        chk("t6_restart_pc1", popped_pc[1], 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage that sits directly upstream of the single-cycle decode/execute datapath. It owns the fetch PC, issues word requests to instruction memory over a valid/ready interface, and buffers returned words with their PCs in an in-order prefetch queue. The queue presents instructions to decode with a valid/ready handshake and is flushed by branch/jump redirects. Stale in-flight memory responses are discarded after a flush.

## Interface
- DEPTH, 4, queue entries and maximum in-flight requests; power of 2, ≥2
- RESET_PC, 32'h0, fetch address after reset; word-aligned
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  32  byte address of requested word
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response word valid; responses return in request order
- imem_rsp_data  in  32  returned instruction word
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new fetch target
- out_valid  out  1  queue head valid toward decode
- out_instr  out  32  instruction at queue head
- out_pc  out  32  PC of instruction at queue head
- out_ready  in  1  decode consumes head this cycle

## Operation
- State: fetch_pc, queue (DEPTH × {pc, instr}), rd/wr pointers, count (0..DEPTH), outstanding (accepted requests not yet answered), drop_cnt (responses to discard).
- Request: imem_req_valid = reset deasserted AND count + outstanding < DEPTH; imem_req_addr = fetch_pc. Request accepted when imem_req_valid and imem_req_ready are both high; then fetch_pc += 4. Wraps 32'hFFFF_FFFC → 0.
- imem_req_addr must stay stable while imem_req_valid=1 and imem_req_ready=0.
- Each accepted request records its PC in a DEPTH-deep PC FIFO so responses are tagged in order.
- Response: when imem_rsp_valid=1 and drop_cnt=0, the word and its tagged PC are written to the queue tail, and outstanding decrements. When drop_cnt>0, the word is discarded, and both drop_cnt and outstanding decrement.
- Output: out_valid = count>0; out_instr/out_pc = head entry. The head pops when out_valid and out_ready are both high.
- Redirect (redirect_valid=1, reset deasserted):
  - Queue is emptied: count←0 and pointers reset.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}; the low bits are silently cleared.
  - drop_cnt ← the outstanding count after this cycle's accounting. This includes a request accepted in the same cycle. A response arriving in the same cycle is dropped, not counted.
- Simultaneous events in the redirect cycle:
  - A head pop with out_ready=1 completes; decode has consumed that instruction.
  - A response arriving that cycle is dropped.
  - A request accepted that cycle used the old address and is counted in drop_cnt.
  - The fetch_pc update from the redirect overrides the +4 increment.
- Queue full (count=DEPTH): no response can arrive, because the credit rule makes that impossible. Requests stall until decode pops.
- Simultaneous response write and head pop: count is unchanged.
- Reset asserted (any time, including mid-operation):
  - All state clears immediately: count, outstanding, drop_cnt = 0, and fetch_pc = RESET_PC.
  - Responses to requests issued before reset are the memory's responsibility; memory is reset together with this block.

## Timing
- Reset values of outputs:
  - imem_req_valid=0.
  - imem_req_addr=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0.
- After reset deassertion, imem_req_valid=1 combinationally in the first cycle.
- Latency: request accepted at edge N, with memory answering in the next cycle, gives rsp_valid in cycle N+1 and out_valid in cycle N+2. There is no response-to-output bypass.
- Sustained throughput is 1 instruction/cycle with single-cycle memory, imem_req_ready=1 and out_ready=1.
- After a redirect at edge R:
  - The first request to the new target is issued in cycle R+1 if credit allows.
  - out_valid stays 0 in the cycle following R until a new-target response lands.

## Test plan
- Reset, then single-cycle memory returning data = addr ^ 32'hA5A5_0000, with out_ready=1 → out_pc sequence 0,4,8,12,16 with matching out_instr, first out_valid 2 cycles after the first request, then one per cycle.
- out_ready=0 from reset → exactly 4 requests accepted (0x0,0x4,0x8,0xC), then imem_req_valid=0 while count=4; raising out_ready pops 0x0 and the next request 0x10 is issued.
- 3-cycle memory latency with 2 requests in flight (0x0,0x4), redirect_pc=0x20 → both responses discarded, next out_pc=0x20 with its word, no 0x0/0x4 ever presented after the redirect.
- redirect_pc=0x23 → imem_req_addr=0x20 next cycle; out_pc sequence 0x20,0x24.
- imem_req_ready held 0 for 3 cycles at fetch_pc=0x8 → imem_req_addr stays 0x8 with valid=1, and no PC advance until accepted.
- reset driven low mid-stream with count=3 → out_valid=0 and imem_req_valid=0 immediately; after release, fetching restarts at RESET_PC=0.
